// File: rtl/wb_pkg.sv
// Shared constants and entry type for the writeback buffer.
package wb_pkg;

  localparam int DEPTH      = 8;
  localparam int PTR_WIDTH  = 3;
  localparam int ADDR_WIDTH = 15;
  localparam int DATA_WIDTH = 16;

  // One buffered eviction: word address (bits [15:1]) and its data.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Address CAM over the buffer entries. Scans from the youngest entry
// (tail-1) back to the head and reports the first masked match as a
// one-hot vector, so the caller always sees the most recent copy.
module wb_match #(
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int ADDR_WIDTH = 15
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
  input  logic [DEPTH-1:0]                 mask,
  input  logic [PTR_WIDTH-1:0]             head,
  input  logic [PTR_WIDTH-1:0]             tail,
  input  logic [ADDR_WIDTH-1:0]            lookup,
  output logic [DEPTH-1:0]                 match_vec,
  output logic                             hit
);

  logic [PTR_WIDTH-1:0] idx;
  logic                 found;
  logic                 past_head;

  // Youngest-first priority scan; stops once the head slot has been examined.
  always_comb begin
    match_vec = '0;
    idx       = '0;
    found     = 1'b0;
    past_head = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PTR_WIDTH'(k + 1);
      if (!found && !past_head && mask[idx] && (addrs[idx] == lookup)) begin
        match_vec[idx] = 1'b1;
        found          = 1'b1;
      end
      if (idx == head) begin
        past_head = 1'b1;
      end
    end
  end

  assign hit = found;

endmodule

// File: rtl/writeback_buffer.sv
// Coalescing eviction buffer between the cache and the data-memory write
// port, with a registered snoop lookup so reads see not-yet-drained data.
//
// Write handshake: mem_wen is the valid, mem_wready the ready. A write
// transfers on a rising edge where both are high. While mem_wen is high and
// mem_wready low, mem_waddr/mem_wdata hold stable; mem_wen never drops
// without a transfer (except on reset). For this reason the head entry is
// never coalesced into.
module writeback_buffer #(
  parameter int DEPTH      = wb_pkg::DEPTH,
  parameter int PTR_WIDTH  = wb_pkg::PTR_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  store_en,
  input  logic [ADDR_WIDTH:1]   store_addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  full,
  output logic                  overflow,
  output logic [PTR_WIDTH:0]    count,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH:1]   mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic [ADDR_WIDTH:1]   snoop_addr,
  output logic                  snoop_hit,
  output logic [DATA_WIDTH-1:0] snoop_data
);

  import wb_pkg::*;

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);

  wb_entry_t                       entries [DEPTH];
  logic [PTR_WIDTH-1:0]            head_q;
  logic [PTR_WIDTH-1:0]            tail_q;
  logic [PTR_WIDTH:0]              count_q;
  logic                            overflow_q;
  logic                            snoop_hit_q;
  logic [DATA_WIDTH-1:0]           snoop_data_q;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addrs;
  logic [DEPTH-1:0]                occupied;
  logic [DEPTH-1:0]                head_onehot;
  logic [DEPTH-1:0]                coalesce_mask;
  logic [DEPTH-1:0]                coalesce_vec;
  logic [DEPTH-1:0]                snoop_vec;
  logic                            coalesce_hit;
  logic                            snoop_cam_hit;
  logic [PTR_WIDTH-1:0]            off;
  logic [DATA_WIDTH-1:0]           snoop_cam_data;

  logic is_full;
  logic pop;
  logic coalesce;
  logic alloc;
  logic drop;
  logic store_snoop;

  // Occupancy: slot i is live when its distance from head is below count.
  always_comb begin
    entry_addrs = '0;
    occupied    = '0;
    head_onehot = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addrs[i] = entries[i].addr;
      off            = PTR_WIDTH'(i) - head_q;
      occupied[i]    = ({1'b0, off} < count_q);
    end
    head_onehot[head_q] = 1'b1;
  end

  assign coalesce_mask = occupied & ~head_onehot;

  wb_match #(
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_coalesce_match (
    .addrs     (entry_addrs),
    .mask      (coalesce_mask),
    .head      (head_q),
    .tail      (tail_q),
    .lookup    (store_addr),
    .match_vec (coalesce_vec),
    .hit       (coalesce_hit)
  );

  wb_match #(
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_snoop_match (
    .addrs     (entry_addrs),
    .mask      (occupied),
    .head      (head_q),
    .tail      (tail_q),
    .lookup    (snoop_addr),
    .match_vec (snoop_vec),
    .hit       (snoop_cam_hit)
  );

  assign is_full     = (count_q == DEPTH_C);
  assign pop         = mem_wen & mem_wready;
  assign coalesce    = store_en & coalesce_hit;
  assign alloc       = store_en & ~coalesce_hit & (~is_full | pop);
  assign drop        = store_en & ~coalesce_hit & is_full & ~pop;
  assign store_snoop = store_en & (store_addr == snoop_addr);

  // Select the data of the single (one-hot) snoop match.
  always_comb begin
    snoop_cam_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (snoop_vec[i]) begin
        snoop_cam_data = snoop_cam_data | entries[i].data;
      end
    end
  end

  // Pointer, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= head_q + PTR_WIDTH'(1);
      end
      if (alloc) begin
        tail_q <= tail_q + PTR_WIDTH'(1);
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + (PTR_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage: allocate at tail, or overwrite data of a matching non-head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && (tail_q == PTR_WIDTH'(i))) begin
          entries[i].addr <= store_addr;
          entries[i].data <= store_data;
        end else if (coalesce && coalesce_vec[i]) begin
          entries[i].data <= store_data;
        end
      end
    end
  end

  // Registered snoop result; a same-cycle store is younger than any entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snoop_hit_q  <= 1'b0;
      snoop_data_q <= '0;
    end else if (store_snoop) begin
      snoop_hit_q  <= 1'b1;
      snoop_data_q <= store_data;
    end else begin
      snoop_hit_q  <= snoop_cam_hit;
      snoop_data_q <= snoop_cam_data;
    end
  end

  assign count      = count_q;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign mem_wen    = (count_q != '0);
  assign mem_waddr  = entries[head_q].addr;
  assign mem_wdata  = entries[head_q].data;
  assign snoop_hit  = snoop_hit_q;
  assign snoop_data = snoop_data_q;

endmodule
